// File: rtl/minterm_sweeper_if.sv
// Handshake/result bundle between the exhaustive sweeper and its controller/DUT harness.
interface minterm_sweeper_if #(
   parameter int unsigned N = 4
);
   localparam int unsigned VECS  = 2 ** N;
   localparam int unsigned ERR_W = N + 1;

   logic              start;
   logic [VECS-1:0]   exp_tt;
   logic              dut_f;
   logic [N-1:0]      vec;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ERR_W-1:0]  err_cnt;
   logic [N-1:0]      first_err;
   logic              first_err_vld;

   // Sweeper side: drives the vector and results, observes the DUT response.
   modport master (
      input  start, exp_tt, dut_f,
      output vec, busy, done, pass, err_cnt, first_err, first_err_vld
   );

   // Controller side: requests sweeps, supplies the DUT response, reads results.
   modport slave (
      output start, exp_tt, dut_f,
      input  vec, busy, done, pass, err_cnt, first_err, first_err_vld
   );
endinterface

// File: rtl/minterm_sweeper.sv
// Exhaustive truth-table sweeper/checker for an N-input, 1-output combinational DUT.
// Define SWEEP_GRAY_EN to sweep in reflected-binary Gray order instead of binary order.
module minterm_sweeper #(
   parameter int unsigned N    = 4,
   parameter int unsigned HOLD = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   minterm_sweeper_if.master    bus
);
   localparam int unsigned VECS   = 2 ** N;
   localparam int unsigned ERR_W  = N + 1;
   localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q,         state_n;
   logic [N-1:0]       cnt_q,           cnt_n;
   logic [HOLD_W-1:0]  hold_q,          hold_n;
   logic [VECS-1:0]    exp_q,           exp_n;
   logic [N-1:0]       vec_q,           vec_n;
   logic               busy_q,          busy_n;
   logic               done_q,          done_n;
   logic               pass_q,          pass_n;
   logic [ERR_W-1:0]   err_cnt_q,       err_cnt_n;
   logic [N-1:0]       first_err_q,     first_err_n;
   logic               first_err_vld_q, first_err_vld_n;
   logic               mismatch_c;

   // Map the internal binary count onto the driven sequence vector.
   function automatic logic [N-1:0] seq_vec(input logic [N-1:0] b);
`ifdef SWEEP_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   assign mismatch_c = (bus.dut_f != exp_q[vec_q]);

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         hold_q          <= '0;
         exp_q           <= '0;
         vec_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         err_cnt_q       <= '0;
         first_err_q     <= '0;
         first_err_vld_q <= 1'b0;
      end else begin
         state_q         <= state_n;
         cnt_q           <= cnt_n;
         hold_q          <= hold_n;
         exp_q           <= exp_n;
         vec_q           <= vec_n;
         busy_q          <= busy_n;
         done_q          <= done_n;
         pass_q          <= pass_n;
         err_cnt_q       <= err_cnt_n;
         first_err_q     <= first_err_n;
         first_err_vld_q <= first_err_vld_n;
      end
   end

   // Next-state and next-result logic.
   always_comb begin
      state_n         = state_q;
      cnt_n           = cnt_q;
      hold_n          = hold_q;
      exp_n           = exp_q;
      vec_n           = vec_q;
      busy_n          = busy_q;
      done_n          = done_q;
      pass_n          = pass_q;
      err_cnt_n       = err_cnt_q;
      first_err_n     = first_err_q;
      first_err_vld_n = first_err_vld_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_n         = ST_DRIVE;
               exp_n           = bus.exp_tt;
               cnt_n           = '0;
               vec_n           = seq_vec('0);
               hold_n          = '0;
               busy_n          = 1'b1;
               done_n          = 1'b0;
               pass_n          = 1'b0;
               err_cnt_n       = '0;
               first_err_n     = '0;
               first_err_vld_n = 1'b0;
            end
         end

         ST_DRIVE: begin
            if (hold_q != HOLD_LAST) begin
               hold_n = hold_q + HOLD_W'(1);
            end else begin
               hold_n = '0;
               if (mismatch_c) begin
                  err_cnt_n = err_cnt_q + ERR_W'(1);
                  if (!first_err_vld_q) begin
                     first_err_n     = vec_q;
                     first_err_vld_n = 1'b1;
                  end
               end
               // The count reaching all-ones marks the last vector in either order.
               if (cnt_q == {N{1'b1}}) begin
                  state_n = ST_DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  pass_n  = (err_cnt_n == '0);
               end else begin
                  cnt_n = cnt_q + N'(1);
                  vec_n = seq_vec(cnt_n);
               end
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign bus.vec           = vec_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.err_cnt       = err_cnt_q;
   assign bus.first_err     = first_err_q;
   assign bus.first_err_vld = first_err_vld_q;
endmodule

// File: tb/tb_minterm_sweeper.sv
// Directed bench for minterm_sweeper: N=4/HOLD=2 sweeps plus an N=3/HOLD=1 sequence-order check.
module tb_minterm_sweeper;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   t0  = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [15:0] model_tt = 16'h0000;
   logic        flip_en  = 1'b0;
   logic        tie0     = 1'b0;

   minterm_sweeper_if #(.N(4)) bus4 ();
   minterm_sweeper_if #(.N(3)) bus3 ();

   minterm_sweeper #(.N(4), .HOLD(2)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.master));
   minterm_sweeper #(.N(3), .HOLD(1)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.master));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural DUT: ideal truth table, optionally with vector 5 inverted or output stuck at 0.
   assign bus4.dut_f = tie0 ? 1'b0 : (model_tt[bus4.vec] ^ (flip_en && (bus4.vec == 4'd5)));
   assign bus3.dut_f = 1'b0;

`ifdef SWEEP_GRAY_EN
   localparam logic [3:0] LAST4 = 4'd8;
   logic [2:0] seq3 [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
   localparam logic [3:0] LAST4 = 4'd15;
   logic [2:0] seq3 [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic start4(input logic [15:0] tt);
      @(negedge clk);
      bus4.exp_tt = tt;
      bus4.start  = 1'b1;
      @(negedge clk);
      bus4.start  = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done4(input string tag);
      int n = 0;
      while (!bus4.done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(cyc - t0), 32'd32);
   endtask

   task automatic wait_vec4(input string tag, input logic [3:0] v);
      int n = 0;
      while (bus4.vec != v && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(bus4.vec), 32'(v));
   endtask

   task automatic check_reset4(input string tag);
      check({tag, "_vec"},  32'(bus4.vec), 32'd0);
      check({tag, "_busy"}, 32'(bus4.busy), 32'd0);
      check({tag, "_done"}, 32'(bus4.done), 32'd0);
      check({tag, "_pass"}, 32'(bus4.pass), 32'd0);
      check({tag, "_err"},  32'(bus4.err_cnt), 32'd0);
      check({tag, "_fe"},   32'(bus4.first_err), 32'd0);
      check({tag, "_fev"},  32'(bus4.first_err_vld), 32'd0);
   endtask

   initial begin
      bus4.start  = 1'b0;
      bus4.exp_tt = 16'h0000;
      bus3.start  = 1'b0;
      bus3.exp_tt = 8'h00;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset4("rst0");

      // Ideal DUT: clean pass.
      model_tt = 16'hA5C3;
      start4(16'hA5C3);
      check("t1_busy", 32'(bus4.busy), 32'd1);
      wait_done4("t1_lat");
      check("t1_done", 32'(bus4.done), 32'd1);
      check("t1_busy_end", 32'(bus4.busy), 32'd0);
      check("t1_pass", 32'(bus4.pass), 32'd1);
      check("t1_err", 32'(bus4.err_cnt), 32'd0);
      check("t1_fev", 32'(bus4.first_err_vld), 32'd0);
      check("t1_vec_last", 32'(bus4.vec), 32'(LAST4));

      // Single fault at vector 5.
      flip_en = 1'b1;
      start4(16'hA5C3);
      wait_done4("t2_lat");
      check("t2_err", 32'(bus4.err_cnt), 32'd1);
      check("t2_fe", 32'(bus4.first_err), 32'd5);
      check("t2_fev", 32'(bus4.first_err_vld), 32'd1);
      check("t2_pass", 32'(bus4.pass), 32'd0);
      flip_en = 1'b0;

      // Output stuck at 0 against a table with vectors 0..7 high.
      tie0 = 1'b1;
      start4(16'h00FF);
      wait_done4("t3_lat");
      check("t3_err", 32'(bus4.err_cnt), 32'd8);
      check("t3_fe", 32'(bus4.first_err), 32'd0);
      check("t3_pass", 32'(bus4.pass), 32'd0);
      repeat (3) @(negedge clk);
      check("t3_hold_err", 32'(bus4.err_cnt), 32'd8);
      check("t3_hold_done", 32'(bus4.done), 32'd1);
      tie0 = 1'b0;

      // Reset mid-sweep, then a clean rerun.
      model_tt = 16'hA5C3;
      flip_en  = 1'b1;
      start4(16'hA5C3);
      wait_vec4("t4_reach7", 4'd7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset4("t4_rst");
      flip_en = 1'b0;
      start4(16'hA5C3);
      wait_done4("t4_lat");
      check("t4_pass", 32'(bus4.pass), 32'd1);

      // Start and new table during a sweep are ignored.
      start4(16'hA5C3);
      wait_vec4("t5_reach3", 4'd3);
      bus4.start  = 1'b1;
      bus4.exp_tt = 16'h0000;
      @(negedge clk);
      bus4.start  = 1'b0;
      wait_done4("t5_lat");
      check("t5_pass", 32'(bus4.pass), 32'd1);
      check("t5_err", 32'(bus4.err_cnt), 32'd0);

      // rst beats start on the same edge.
      @(negedge clk);
      rst = 1'b1;
      bus4.start = 1'b1;
      @(negedge clk);
      check("t6_busy", 32'(bus4.busy), 32'd0);
      check("t6_done", 32'(bus4.done), 32'd0);
      rst = 1'b0;
      bus4.start = 1'b0;

      // N=3, HOLD=1 sequence order.
      @(negedge clk);
      bus3.start = 1'b1;
      @(negedge clk);
      bus3.start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("t7_vec%0d", k), 32'(bus3.vec), 32'(seq3[k]));
         check($sformatf("t7_busy%0d", k), 32'(bus3.done), 32'd0);
`ifdef SWEEP_GRAY_EN
         if (k > 0)
            check($sformatf("t7_onebit%0d", k), 32'($countones(bus3.vec ^ seq3[k-1])), 32'd1);
`endif
         @(negedge clk);
      end
      check("t7_done", 32'(bus3.done), 32'd1);
      check("t7_pass", 32'(bus3.pass), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
